// File: rtl/aq_ifu_ibuf_ptr_ctrl.sv
// Instruction buffer pointer control.
// Tracks write pointer, read pointer and occupancy of an 8-entry halfword
// buffer. Generates per-entry create/retire strobes, assembles the head
// instruction (16- or 32-bit) for decode, and raises back-pressure to fetch.
module aq_ifu_ibuf_ptr_ctrl #(
    parameter int ENTRY_NUM = 8
) (
    input  logic                      ibuf_cpuclk,
    input  logic                      cpurst_b,
    input  logic                      ibuf_flush_en,
    input  logic [1:0]                ifu_ibuf_half_vld,
    input  logic [31:0]               ifu_ibuf_data,
    output logic                      ibuf_ifu_full,
    output logic [ENTRY_NUM-1:0]      ibuf_entry_create_en,
    output logic [16*ENTRY_NUM-1:0]   ibuf_entry_create_inst,
    input  logic [ENTRY_NUM-1:0]      ibuf_entry_vld,
    input  logic [16*ENTRY_NUM-1:0]   ibuf_entry_inst,
    output logic [ENTRY_NUM-1:0]      ibuf_entry_retire_en,
    output logic                      ibuf_idu_inst_vld,
    output logic [31:0]               ibuf_idu_inst,
    input  logic                      idu_ibuf_stall
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W-1:0] wptr_next;
    logic [PTR_W-1:0] rptr_reg;
    logic [PTR_W-1:0] rptr_next;
    logic [CNT_W-1:0] entry_cnt_reg;
    logic [CNT_W-1:0] entry_cnt_next;

    logic [PTR_W-1:0] wptr_p1;
    logic [PTR_W-1:0] rptr_p1;
    logic             write_ok;
    logic [1:0]       create_num;
    logic [1:0]       retire_num;
    logic [15:0]      first_half;
    logic [15:0]      head_lo;
    logic [15:0]      head_hi;
    logic             head_is_32;
    logic             pop;
    logic [15:0]      entry_inst_arr [ENTRY_NUM];

    // Occupancy of 7 or more leaves no room for a guaranteed two-halfword write;
    // derived only from the registered count so fetch sees no combinational loop.
    assign ibuf_ifu_full = (entry_cnt_reg > CNT_W'(ENTRY_NUM - 2));

    assign wptr_p1 = wptr_reg + PTR_W'(1);
    assign rptr_p1 = rptr_reg + PTR_W'(1);

    // Writes are dropped during flush and whenever fetch ignores back-pressure.
    assign write_ok   = !ibuf_flush_en && !ibuf_ifu_full;
    assign create_num = write_ok ? ({1'b0, ifu_ibuf_half_vld[0]} + {1'b0, ifu_ibuf_half_vld[1]})
                                 : 2'd0;

    // The first valid halfword always lands at wptr; a lone high halfword
    // is therefore shifted down to the wptr slot.
    assign first_half = ifu_ibuf_half_vld[0] ? ifu_ibuf_data[15:0] : ifu_ibuf_data[31:16];

    // Head decode: low two bits of 2'b11 mark a 32-bit instruction needing rptr+1.
    assign head_lo    = entry_inst_arr[rptr_reg];
    assign head_hi    = entry_inst_arr[rptr_p1];
    assign head_is_32 = (head_lo[1:0] == 2'b11);

    assign ibuf_idu_inst_vld = !ibuf_flush_en && ibuf_entry_vld[rptr_reg]
                             && (!head_is_32 || ibuf_entry_vld[rptr_p1]);
    assign ibuf_idu_inst     = head_is_32 ? {head_hi, head_lo} : {16'h0000, head_lo};

    assign pop        = ibuf_idu_inst_vld && !idu_ibuf_stall;
    assign retire_num = pop ? (head_is_32 ? 2'd2 : 2'd1) : 2'd0;

    generate
        for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
            logic hit_w0;
            logic hit_w1;
            logic hit_r0;
            logic hit_r1;

            assign hit_w0 = (wptr_reg == IDX);
            assign hit_w1 = (wptr_p1 == IDX);
            assign hit_r0 = (rptr_reg == IDX);
            assign hit_r1 = (rptr_p1 == IDX);

            assign entry_inst_arr[gi] = ibuf_entry_inst[16*gi +: 16];

            assign ibuf_entry_create_en[gi] = write_ok
                && ((hit_w0 && (|ifu_ibuf_half_vld)) || (hit_w1 && (&ifu_ibuf_half_vld)));

            // Slot wptr takes the first valid halfword, slot wptr+1 the high one.
            assign ibuf_entry_create_inst[16*gi +: 16] = hit_w0 ? first_half
                                                                : ifu_ibuf_data[31:16];

            assign ibuf_entry_retire_en[gi] = pop && (hit_r0 || (head_is_32 && hit_r1));
        end
    endgenerate

    // Next-state for pointers and occupancy; flush returns everything to empty.
    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        entry_cnt_next = entry_cnt_reg;
        if (ibuf_flush_en) begin
            wptr_next      = '0;
            rptr_next      = '0;
            entry_cnt_next = '0;
        end else begin
            wptr_next      = wptr_reg + PTR_W'(create_num);
            rptr_next      = rptr_reg + PTR_W'(retire_num);
            entry_cnt_next = entry_cnt_reg + CNT_W'(create_num) - CNT_W'(retire_num);
        end
    end

    // Pointer and occupancy registers with asynchronous active-low reset.
    always_ff @(posedge ibuf_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            entry_cnt_reg <= '0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            entry_cnt_reg <= entry_cnt_next;
        end
    end

endmodule

// File: tb/tb_aq_ifu_ibuf_ptr_ctrl.sv
// Self-checking bench for aq_ifu_ibuf_ptr_ctrl. A small behavioural model of
// the eight ibuf entry slots closes the loop between create/retire strobes
// and the entry vld/inst inputs. Each vector is one clock cycle.
module tb_aq_ifu_ibuf_ptr_ctrl;

    logic          clk;
    logic          rst_b;
    logic          flush;
    logic [1:0]    half_vld;
    logic [31:0]   data;
    logic          full;
    logic [7:0]    create_en;
    logic [127:0]  create_inst;
    logic [7:0]    ent_vld;
    logic [127:0]  ent_inst_flat;
    logic [7:0]    retire_en;
    logic          inst_vld;
    logic [31:0]   inst;
    logic          stall;

    logic [15:0]   ent_inst [8];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        flush;
        logic [1:0]  half;
        logic [31:0] data;
        logic        stall;
        logic [7:0]  c_en;
        logic [7:0]  r_en;
        logic        ivld;
        logic [31:0] inst;
        logic        full;
    } vec_t;

    vec_t vecs[$];

    aq_ifu_ibuf_ptr_ctrl #(.ENTRY_NUM(8)) dut (
        .ibuf_cpuclk            (clk),
        .cpurst_b               (rst_b),
        .ibuf_flush_en          (flush),
        .ifu_ibuf_half_vld      (half_vld),
        .ifu_ibuf_data          (data),
        .ibuf_ifu_full          (full),
        .ibuf_entry_create_en   (create_en),
        .ibuf_entry_create_inst (create_inst),
        .ibuf_entry_vld         (ent_vld),
        .ibuf_entry_inst        (ent_inst_flat),
        .ibuf_entry_retire_en   (retire_en),
        .ibuf_idu_inst_vld      (inst_vld),
        .ibuf_idu_inst          (inst),
        .idu_ibuf_stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry slot model: vld set on create, cleared on retire or flush.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ent_vld <= '0;
        end else if (flush) begin
            ent_vld <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (create_en[i])      ent_vld[i] <= 1'b1;
                else if (retire_en[i]) ent_vld[i] <= 1'b0;
            end
        end
    end

    // Entry slot data capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (create_en[i]) ent_inst[i] <= create_inst[16*i +: 16];
        end
    end

    // Repack slot data onto the flat entry bus.
    always_comb begin
        ent_inst_flat = '0;
        for (int i = 0; i < 8; i++) ent_inst_flat[16*i +: 16] = ent_inst[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic [1:0] h, input logic [31:0] d, input logic st,
                       input logic [7:0] ce, input logic [7:0] re, input logic iv,
                       input logic [31:0] in, input logic fu);
        vec_t v;
        v.flush = fl; v.half = h; v.data = d; v.stall = st;
        v.c_en = ce; v.r_en = re; v.ivld = iv; v.inst = in; v.full = fu;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs (called just after a rising edge), compare on the
    // falling edge, then advance to just after the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        flush = v.flush; half_vld = v.half; data = v.data; stall = v.stall;
        @(negedge clk);
        check({tag, " create_en"}, {24'h0, create_en}, {24'h0, v.c_en});
        check({tag, " retire_en"}, {24'h0, retire_en}, {24'h0, v.r_en});
        check({tag, " inst_vld"},  {31'h0, inst_vld},  {31'h0, v.ivld});
        check({tag, " full"},      {31'h0, full},      {31'h0, v.full});
        if (v.ivld) check({tag, " inst"}, inst, v.inst);
        $display("%s: flush=%b half=%b data=%h stall=%b -> create=%h retire=%h vld=%b inst=%h full=%b",
                 tag, v.flush, v.half, v.data, v.stall, create_en, retire_en, inst_vld, inst, full);
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input string tag, input logic fl, input logic [1:0] h, input logic [31:0] d,
                       input logic st, input logic [7:0] ce, input logic [7:0] re, input logic iv,
                       input logic [31:0] in, input logic fu);
        vec_t v;
        v.flush = fl; v.half = h; v.data = d; v.stall = st;
        v.c_en = ce; v.r_en = re; v.ivld = iv; v.inst = in; v.full = fu;
        apply(tag, v);
    endtask

    initial begin
        rst_b = 1'b0; flush = 1'b0; half_vld = 2'b00; data = '0; stall = 1'b0;

        // Table: fl half data stall | create retire vld inst full
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0,          1'b0); // 0 idle
        add(1'b0, 2'b01, 32'h0000_4501, 1'b0, 8'h01, 8'h00, 1'b0, 32'h0,          1'b0); // 1 16-bit write
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h01, 1'b1, 32'h0000_4501, 1'b0); // 2 pop
        add(1'b0, 2'b11, 32'h0010_0093, 1'b0, 8'h06, 8'h00, 1'b0, 32'h0,          1'b0); // 3 pair write
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h06, 1'b1, 32'h0010_0093, 1'b0); // 4 32-bit pop
        add(1'b0, 2'b01, 32'h0000_0093, 1'b0, 8'h08, 8'h00, 1'b0, 32'h0,          1'b0); // 5 split low
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0,          1'b0); // 6 split wait
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0,          1'b0); // 7 split wait
        add(1'b0, 2'b01, 32'h0000_0010, 1'b0, 8'h10, 8'h00, 1'b0, 32'h0,          1'b0); // 8 split high
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h18, 1'b1, 32'h0010_0093, 1'b0); // 9 split pop
        add(1'b0, 2'b10, 32'h1234_0000, 1'b0, 8'h20, 8'h00, 1'b0, 32'h0,          1'b0); // 10 high-only
        add(1'b0, 2'b11, 32'hABCD_0003, 1'b1, 8'hC0, 8'h00, 1'b1, 32'h0000_1234, 1'b0); // 11 stalled
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h20, 1'b1, 32'h0000_1234, 1'b0); // 12
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'hC0, 1'b1, 32'hABCD_0003, 1'b0); // 13
        add(1'b0, 2'b11, 32'h2220_1110, 1'b0, 8'h03, 8'h00, 1'b0, 32'h0,          1'b0); // 14
        add(1'b0, 2'b11, 32'h4440_3330, 1'b0, 8'h0C, 8'h01, 1'b1, 32'h0000_1110, 1'b0); // 15 write+pop
        add(1'b0, 2'b11, 32'h6660_5550, 1'b0, 8'h30, 8'h02, 1'b1, 32'h0000_2220, 1'b0); // 16
        add(1'b0, 2'b01, 32'h0000_7770, 1'b0, 8'h40, 8'h04, 1'b1, 32'h0000_3330, 1'b0); // 17
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h08, 1'b1, 32'h0000_4440, 1'b0); // 18
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h10, 1'b1, 32'h0000_5550, 1'b0); // 19
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h20, 1'b1, 32'h0000_6660, 1'b0); // 20
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h40, 1'b1, 32'h0000_7770, 1'b0); // 21
        add(1'b0, 2'b11, 32'hABCD_0003, 1'b0, 8'h81, 8'h00, 1'b0, 32'h0,          1'b0); // 22 wrap write
        add(1'b0, 2'b00, 32'h0000_0000, 1'b0, 8'h00, 8'h81, 1'b1, 32'hABCD_0003, 1'b0); // 23 wrap pop

        // Reset state, sampled while reset is held.
        #3;
        check("rst full",      {31'h0, full},      32'h0);
        check("rst create_en", {24'h0, create_en}, 32'h0);
        check("rst retire_en", {24'h0, retire_en}, 32'h0);
        check("rst inst_vld",  {31'h0, inst_vld},  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // Fill to full with decode stalled; wptr=rptr=1, count 0 at start.
        seq("fill1", 1'b0, 2'b11, 32'h0, 1'b1, 8'h06, 8'h00, 1'b0, 32'h0, 1'b0);
        seq("fill2", 1'b0, 2'b11, 32'h0, 1'b1, 8'h18, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("fill3", 1'b0, 2'b11, 32'h0, 1'b1, 8'h60, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("fill4", 1'b0, 2'b11, 32'h0, 1'b1, 8'h81, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("drop",  1'b0, 2'b11, 32'hFFFF_FFFF, 1'b1, 8'h00, 8'h00, 1'b1, 32'h0, 1'b1);
        seq("pop8",  1'b0, 2'b00, 32'h0, 1'b0, 8'h00, 8'h02, 1'b1, 32'h0, 1'b1);
        seq("pop7",  1'b0, 2'b00, 32'h0, 1'b0, 8'h00, 8'h04, 1'b1, 32'h0, 1'b1);
        seq("refill",1'b0, 2'b01, 32'h0, 1'b1, 8'h02, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("pop7b", 1'b0, 2'b00, 32'h0, 1'b0, 8'h00, 8'h08, 1'b1, 32'h0, 1'b1);
        seq("pop6",  1'b0, 2'b00, 32'h0, 1'b0, 8'h00, 8'h10, 1'b1, 32'h0, 1'b0);

        // Flush with five entries valid and a write presented.
        seq("flush", 1'b1, 2'b11, 32'h0, 1'b0, 8'h00, 8'h00, 1'b0, 32'h0, 1'b0);
        seq("pflw",  1'b0, 2'b01, 32'h0000_4501, 1'b0, 8'h01, 8'h00, 1'b0, 32'h0, 1'b0);
        seq("pflp",  1'b0, 2'b00, 32'h0, 1'b0, 8'h00, 8'h01, 1'b1, 32'h0000_4501, 1'b0);

        // Asynchronous reset mid-operation from a full buffer.
        seq("rf1", 1'b0, 2'b11, 32'h0, 1'b1, 8'h06, 8'h00, 1'b0, 32'h0, 1'b0);
        seq("rf2", 1'b0, 2'b11, 32'h0, 1'b1, 8'h18, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("rf3", 1'b0, 2'b11, 32'h0, 1'b1, 8'h60, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("rf4", 1'b0, 2'b11, 32'h0, 1'b1, 8'h81, 8'h00, 1'b1, 32'h0, 1'b0);
        seq("rf5", 1'b0, 2'b00, 32'h0, 1'b1, 8'h00, 8'h00, 1'b1, 32'h0, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        check("arst full",      {31'h0, full},      32'h0);
        check("arst retire_en", {24'h0, retire_en}, 32'h0);
        check("arst inst_vld",  {31'h0, inst_vld},  32'h0);
        check("arst create_en", {24'h0, create_en}, 32'h0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        seq("rrw", 1'b0, 2'b01, 32'h0000_4501, 1'b0, 8'h01, 8'h00, 1'b0, 32'h0, 1'b0);
        seq("rrp", 1'b0, 2'b00, 32'h0, 1'b0, 8'h00, 8'h01, 1'b1, 32'h0000_4501, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
